alu_issue_ctrl: RTL and testbench

//  Initiator front-end for the alu: buffers operation commands, launches each onto the alu

---
 rtl/alu_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator front-end for the alu. Commands are buffered in a small FIFO.
//   Each command is launched onto the alu operand bus for exactly one cycle.
//   The block then waits for the alu completion pulse, captures the result
//   and returns it on a valid/ready response port. Only one op is
//   outstanding at a time, and responses come back in command order.
//
// Parameters
//   FIFO_DEPTH      command FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  watchdog limit in cycles (only with ALU_TIMEOUT_EN)
//
// Optional feature
//   ALU_TIMEOUT_EN  when defined, a watchdog ends an op that has run for
//                   TIMEOUT_CYCLES ISSUE/WAIT cycles. That op gets a response
//                   with rsp_c=0 and rsp_err=1. When undefined, WAIT holds
//                   indefinitely and rsp_err is tied to 0.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_op            command payload (64/64/2 bits)
//   rsp_valid/rsp_ready             response handshake
//   rsp_c, rsp_err                  128-bit result, watchdog error flag
//   alu_A, alu_B, alu_opCode        operand bus to the alu (ISSUE only)
//   alu_C, alu_completed            result and one-cycle done pulse from the alu
//   busy                            FSM active or FIFO non-empty
//   stray_cnt                       saturating count of unexpected done pulses
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_a,
  input  logic [63:0]  cmd_b,
  input  logic [1:0]   cmd_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_c,
  output logic         rsp_err,
  output logic [63:0]  alu_A,
  output logic [63:0]  alu_B,
  output logic [1:0]   alu_opCode,
  input  logic [127:0] alu_C,
  input  logic         alu_completed,
  output logic         busy,
  output logic [7:0]   stray_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nx;

  // ---------------- command FIFO ----------------
  logic [129:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic [129:0]     head;

  assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // The head entry leaves the FIFO on the edge that ends the ISSUE cycle.
  assign pop       = (state == S_ISSUE);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
  end

  // ---------------- watchdog ----------------
  logic in_flight;
  logic wd_expire;

  assign in_flight = (state == S_ISSUE) || (state == S_WAIT);

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd;

  // wd holds the index of the current ISSUE/WAIT cycle, starting at 0 in ISSUE.
  // Expiry fires in the TIMEOUT_CYCLES-th such cycle.
  assign wd_expire = in_flight && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                    wd <= '0;
    else if (state == S_IDLE && state_nx == S_ISSUE) wd <= '0;
    else if (in_flight)                             wd <= wd + WD_W'(1);
  end
`else
  // The watchdog limit is only used when the watchdog is built in.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (count != '0) state_nx = S_ISSUE;
      S_ISSUE: state_nx = (alu_completed || wd_expire) ? S_RESP : S_WAIT;
      S_WAIT:  if (alu_completed || wd_expire) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    alu_A      = '0;
    alu_B      = '0;
    alu_opCode = '0;
    if (state == S_ISSUE) begin
      alu_A      = head[63:0];
      alu_B      = head[127:64];
      alu_opCode = head[129:128];
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || (count != '0);

  // ---------------- response capture ----------------
  // A completion pulse beats the watchdog when both land in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        rsp_c <= '0;
    else if (in_flight && alu_completed) rsp_c <= alu_C;
`ifdef ALU_TIMEOUT_EN
    else if (wd_expire)                 rsp_c <= '0;
`endif
  end

`ifdef ALU_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        rsp_err <= 1'b0;
    else if (in_flight && alu_completed) rsp_err <= 1'b0;
    else if (wd_expire)                 rsp_err <= 1'b1;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // ---------------- stray completion counter ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stray_cnt <= '0;
    else if (alu_completed && !in_flight && stray_cnt != 8'hFF)
      stray_cnt <= stray_cnt + 8'd1;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. The bench plays the alu itself: it
//   drives alu_completed/alu_C from the main sequence. It also plays host
//   and consumer. Single-op vectors come from a table. Back-pressure, stalls,
//   stray pulses, the watchdog (ALU_TIMEOUT_EN builds only) and reset are
//   covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_a;
  logic [63:0]  cmd_b;
  logic [1:0]   cmd_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_c;
  logic         rsp_err;
  logic [63:0]  alu_A;
  logic [63:0]  alu_B;
  logic [1:0]   alu_opCode;
  logic [127:0] alu_C;
  logic         alu_completed;
  logic         busy;
  logic [7:0]   stray_cnt;

  alu_issue_ctrl #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_op        (cmd_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_c         (rsp_c),
    .rsp_err       (rsp_err),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_opCode    (alu_opCode),
    .alu_C         (alu_C),
    .alu_completed (alu_completed),
    .busy          (busy),
    .stray_cnt     (stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [1:0]   op;
    int unsigned  dly;   // cycles after ISSUE at which the alu completes
    logic [127:0] c;     // value the alu returns (and expected rsp_c)
  } vec_t;

  vec_t vecs [5];

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  int unsigned  idx, issues, nrsp, cycles;
  logic         accept, outstanding, ok;
  logic [63:0]  out_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int unsigned n);
    cmd_valid = 1'b1;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_op    = v.op;
    chk($sformatf("v%0d_cmd_ready", n), cmd_ready, 1);
    tick();                                   // accepted
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_busy_queued", n), busy, 1);
    chk($sformatf("v%0d_idle_opcode", n), alu_opCode, 0);
    tick();                                   // ISSUE
    chk($sformatf("v%0d_alu_a", n), alu_A, v.a);
    chk($sformatf("v%0d_alu_b", n), alu_B, v.b);
    chk($sformatf("v%0d_alu_op", n), alu_opCode, v.op);
    for (int unsigned k = 0; k < v.dly; k++) begin
      tick();
      if (k == 0) begin
        chk($sformatf("v%0d_wait_alu_a", n), alu_A, 0);
        chk($sformatf("v%0d_wait_rsp_valid", n), rsp_valid, 0);
      end
    end
    alu_completed = 1'b1;
    alu_C         = v.c;
    tick();
    alu_completed = 1'b0;
    alu_C         = '0;
    chk($sformatf("v%0d_rsp_valid", n), rsp_valid, 1);
    chk($sformatf("v%0d_rsp_c", n), rsp_c, v.c);
    chk($sformatf("v%0d_rsp_err", n), rsp_err, 0);
    chk($sformatf("v%0d_resp_alu_a", n), alu_A, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_drop", n), rsp_valid, 0);
    chk($sformatf("v%0d_idle_busy", n), busy, 0);
  endtask

  initial begin
    vecs[0] = '{a: 64'd3, b: 64'd5, op: 2'b01, dly: 4, c: 128'd15};
    vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFF9, b: 64'd9, op: 2'b01, dly: 0,
                c: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1};
    vecs[2] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, op: 2'b00, dly: 1,
                c: 128'h0000_0000_0000_0000_8000_0000_0000_0000};
    vecs[3] = '{a: 64'd100, b: 64'd30, op: 2'b10, dly: 2, c: 128'd70};
    vecs[4] = '{a: 64'h8000_0000_0000_0000, b: 64'd2, op: 2'b01, dly: 3,
                c: 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};

    resetn        = 1'b0;
    cmd_valid     = 1'b0;
    cmd_a         = '0;
    cmd_b         = '0;
    cmd_op        = '0;
    rsp_ready     = 1'b0;
    alu_C         = '0;
    alu_completed = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_A, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stray", stray_cnt, 0);
    resetn = 1'b1;
    tick();

    // ---- single-op vectors ----
    for (int unsigned i = 0; i < 5; i++) run_vec(vecs[i], i);

    // ---- stalled alu, six back-to-back commands ----
    cmd_op      = 2'b11;
    cmd_b       = '0;
    cmd_a       = '0;
    cmd_valid   = 1'b1;
    idx         = 0;
    issues      = 0;
    outstanding = 1'b0;
    out_a       = '0;
    for (int c = 0; c < 10; c++) begin
      accept = cmd_valid && cmd_ready;
      if (alu_opCode == 2'b11) begin
        issues++;
        outstanding = 1'b1;
        out_a       = alu_A;
      end
      tick();
      if (accept) begin
        idx++;
        if (idx < 6) cmd_a = 64'(idx);
        else         cmd_valid = 1'b0;
      end
    end
    chk("stall_accepted", idx, 5);
    chk("stall_issues", issues, 1);
    chk("stall_cmd_ready", cmd_ready, 0);
    chk("stall_first_a", out_a, 0);

    rsp_ready = 1'b1;
    nrsp      = 0;
    cycles    = 0;
    while (nrsp < 6 && cycles < 200) begin
      alu_completed = 1'b0;
      accept        = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        chk($sformatf("order_rsp%0d", nrsp), rsp_c, 128'(nrsp));
        nrsp++;
      end
      if (alu_opCode == 2'b11) begin
        outstanding = 1'b1;
        out_a       = alu_A;
      end else if (outstanding) begin
        alu_completed = 1'b1;
        alu_C         = {64'd0, out_a};
        outstanding   = 1'b0;
      end
      tick();
      cycles++;
      if (accept) begin
        idx++;
        if (idx < 6) cmd_a = 64'(idx);
        else         cmd_valid = 1'b0;
      end
    end
    alu_completed = 1'b0;
    alu_C         = '0;
    rsp_ready     = 1'b0;
    chk("order_rsp_count", nrsp, 6);
    chk("order_all_accepted", idx, 6);
    chk("order_cmd_ready", cmd_ready, 1);
    chk("order_busy", busy, 0);
    chk("order_no_stray", stray_cnt, 0);

    // ---- response back-pressure ----
    cmd_valid = 1'b1;
    cmd_a     = 64'h1111;
    cmd_b     = 64'h2222;
    cmd_op    = 2'b10;
    tick();
    cmd_a     = 64'h3333;
    cmd_b     = 64'h4444;
    cmd_op    = 2'b01;
    tick();
    cmd_valid = 1'b0;
    chk("bp_issue_op", alu_opCode, 2'b10);
    tick();
    alu_completed = 1'b1;
    alu_C         = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
    tick();
    alu_completed = 1'b0;
    alu_C         = '0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid !== 1'b1 || rsp_c !== 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D ||
          alu_opCode !== 2'b00)
        ok = 1'b0;
      tick();
    end
    chk("bp_hold_stable", ok, 1);
    chk("bp_rsp_c", rsp_c, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", rsp_valid, 0);
    chk("bp_idle_op", alu_opCode, 0);
    tick();
    chk("bp_second_op", alu_opCode, 2'b01);
    chk("bp_second_a", alu_A, 64'h3333);
    alu_completed = 1'b1;
    alu_C         = 128'h55;
    tick();
    alu_completed = 1'b0;
    alu_C         = '0;
    chk("bp_second_rsp", rsp_c, 128'h55);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_done_busy", busy, 0);

    // ---- stray completions ----
    alu_completed = 1'b1;
    tick();
    alu_completed = 1'b0;
    chk("stray_one", stray_cnt, 1);
    chk("stray_no_rsp", rsp_valid, 0);
    alu_completed = 1'b1;
    repeat (253) tick();
    chk("stray_254", stray_cnt, 254);
    repeat (46) tick();
    alu_completed = 1'b0;
    chk("stray_sat", stray_cnt, 255);
    chk("stray_idle_busy", busy, 0);

`ifdef ALU_TIMEOUT_EN
    // ---- watchdog expiry ----
    cmd_valid = 1'b1;
    cmd_a     = 64'd1;
    cmd_op    = 2'b01;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("wd_issue", alu_opCode, 2'b01);
    ok = 1'b1;
    for (int k = 1; k < 64; k++) begin
      tick();
      if (rsp_valid !== 1'b0) ok = 1'b0;
    end
    chk("wd_no_early", ok, 1);
    tick();
    chk("wd_rsp_valid", rsp_valid, 1);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rsp_c", rsp_c, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- completion in the expiry cycle wins ----
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    repeat (63) tick();
    alu_completed = 1'b1;
    alu_C         = 128'd7;
    tick();
    alu_completed = 1'b0;
    alu_C         = '0;
    chk("wd_race_valid", rsp_valid, 1);
    chk("wd_race_c", rsp_c, 7);
    chk("wd_race_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    // ---- reset during WAIT with two commands queued ----
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 64'd10;
    tick();
    cmd_a     = 64'd11;
    tick();
    cmd_a     = 64'd12;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    chk("mid_cmd_ready", cmd_ready, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_c", rsp_c, 0);
    chk("arst_alu_a", alu_A, 0);
    chk("arst_alu_op", alu_opCode, 0);
    chk("arst_busy", busy, 0);
    chk("arst_stray", stray_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    alu_completed = 1'b1;
    alu_C         = 128'd99;
    tick();
    alu_completed = 1'b0;
    alu_C         = '0;
    chk("late_stray", stray_cnt, 1);
    chk("late_no_rsp", rsp_valid, 0);
    repeat (3) tick();
    chk("late_still_idle", rsp_valid, 0);
    chk("late_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
